// File: rtl/fifo_flags.sv
// fifo_flags: single-clock FIFO with almost-full/almost-empty thresholds, occupancy count, sticky errors, flush and selectable read mode
// Ports: clk, reset (async, active-low); flush and clr_err are synchronous controls;
//   wr/wr_data with full/almost_full on the write side; rd/rd_data with empty/almost_empty on the read side;
//   count is the current occupancy; overflow/underflow are sticky error flags.
module fifo_flags #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter bit FWFT = 1'b0,
  parameter int AF_LEVEL = (1 << ADDR_WIDTH) - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_LVL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LVL = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_LVL = (ADDR_WIDTH+1)'(AE_LEVEL);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  wa, ra;
  // Flags are pure decodes of the registered count, so acceptance always sees pre-edge state.
  assign full         = count == FULL_LVL;
  assign empty        = count == '0;
  assign almost_full  = count >= AF_LVL;
  assign almost_empty = count <= AE_LVL;
  assign wa           = wr & ~full;
  assign ra           = rd & ~empty;
  // In fall-through mode an empty FIFO presents zero so reset and flush leave rd_data at 0.
  assign rd_data      = FWFT ? (empty ? '0 : mem[rd_ptr]) : rd_q;
  // Storage is not reset; flush suppresses the write it overrides.
  always_ff @(posedge clk)
    if (wa && !flush) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rd_q   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rd_q   <= '0;
    end else begin
      if (wa) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (ra) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      if (ra) rd_q <= mem[rd_ptr];
      count <= count + {ADDR_WIDTH'(0), wa} - {ADDR_WIDTH'(0), ra};
    end
  // Sticky errors: a new set condition beats clr_err in the same cycle; flush leaves them alone.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (wr & full) | (overflow & ~clr_err);
      underflow <= (rd & empty) | (underflow & ~clr_err);
    end
endmodule

// File: tb/tb_fifo_flags.sv
// tb_fifo_flags: table vectors, hand-written corner sequences and random traffic checked against a queue model
module tb_fifo_flags;
  localparam int AW = 2, DW = 8, D = 4, AF = 3, AE = 1;
  logic clk = 0, reset = 0, flush = 0, wr = 0, rd = 0, clr_err = 0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd0, rd1;
  logic [AW:0] cnt0, cnt1;
  logic full0, full1, emp0, emp1, af0, af1, ae0, ae1, ov0, ov1, un0, un1;
  int total = 0, bad = 0;
  logic [DW-1:0] q[$];
  bit m_ov, m_un;
  logic [DW-1:0] m_rq;
  typedef struct {
    bit w, r, c;
    logic [7:0] d;
    int n;
    logic [7:0] r0;
    bit o, u;
  } vec_t;
  vec_t tbl[27];

  fifo_flags #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(1'b0), .AF_LEVEL(AF), .AE_LEVEL(AE)) u0 (
    .clk(clk), .reset(reset), .flush(flush), .wr(wr), .wr_data(wr_data), .full(full0),
    .almost_full(af0), .rd(rd), .rd_data(rd0), .empty(emp0), .almost_empty(ae0),
    .count(cnt0), .overflow(ov0), .underflow(un0), .clr_err(clr_err));
  fifo_flags #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(1'b1), .AF_LEVEL(AF), .AE_LEVEL(AE)) u1 (
    .clk(clk), .reset(reset), .flush(flush), .wr(wr), .wr_data(wr_data), .full(full1),
    .almost_full(af1), .rd(rd), .rd_data(rd1), .empty(emp1), .almost_empty(ae1),
    .count(cnt1), .overflow(ov1), .underflow(un1), .clr_err(clr_err));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, a, e);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ov = 0;
    m_un = 0;
    m_rq = '0;
  endtask

  // Reference: queue semantics decided from pre-edge occupancy.
  task automatic model_step();
    int n = q.size();
    m_ov = (wr && n == D) ? 1'b1 : clr_err ? 1'b0 : m_ov;
    m_un = (rd && n == 0) ? 1'b1 : clr_err ? 1'b0 : m_un;
    if (flush) begin
      q.delete();
      m_rq = '0;
    end else begin
      if (rd && n > 0) m_rq = q.pop_front();
      if (wr && n < D) q.push_back(wr_data);
    end
  endtask

  task automatic cmp_model(input string t);
    int n = q.size();
    chk({t, ".count0"}, cnt0, n);
    chk({t, ".count1"}, cnt1, n);
    chk({t, ".full"}, {full0, full1}, {2{n == D}});
    chk({t, ".empty"}, {emp0, emp1}, {2{n == 0}});
    chk({t, ".afull"}, {af0, af1}, {2{n >= AF}});
    chk({t, ".aempty"}, {ae0, ae1}, {2{n <= AE}});
    chk({t, ".ovf"}, {ov0, ov1}, {2{m_ov}});
    chk({t, ".unf"}, {un0, un1}, {2{m_un}});
    chk({t, ".rd_reg"}, rd0, m_rq);
    if (n > 0) chk({t, ".rd_fwft"}, rd1, q[0]);
  endtask

  task automatic cyc(input bit w, input bit r, input bit f, input bit c, input logic [7:0] d, input string t);
    wr = w;
    rd = r;
    flush = f;
    clr_err = c;
    wr_data = d;
    @(posedge clk);
    model_step();
    #1;
    cmp_model(t);
  endtask

  task automatic chk_reset(input string t);
    chk({t, ".count"}, {cnt0, cnt1}, '0);
    chk({t, ".empty"}, {emp0, emp1, ae0, ae1}, 4'b1111);
    chk({t, ".full"}, {full0, full1, af0, af1}, 4'b0000);
    chk({t, ".err"}, {ov0, ov1, un0, un1}, 4'b0000);
    chk({t, ".rd_data"}, rd0, 8'h00);
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 8'h01, 1, 8'h00, 0, 0};
    tbl[1]  = '{1, 0, 0, 8'h02, 2, 8'h00, 0, 0};
    tbl[2]  = '{1, 0, 0, 8'h03, 3, 8'h00, 0, 0};
    tbl[3]  = '{1, 0, 0, 8'h04, 4, 8'h00, 0, 0};
    tbl[4]  = '{1, 0, 0, 8'h05, 4, 8'h00, 1, 0};
    tbl[5]  = '{0, 1, 0, 8'h00, 3, 8'h01, 1, 0};
    tbl[6]  = '{0, 1, 0, 8'h00, 2, 8'h02, 1, 0};
    tbl[7]  = '{0, 1, 0, 8'h00, 1, 8'h03, 1, 0};
    tbl[8]  = '{0, 1, 0, 8'h00, 0, 8'h04, 1, 0};
    tbl[9]  = '{0, 1, 0, 8'h00, 0, 8'h04, 1, 1};
    tbl[10] = '{0, 0, 1, 8'h00, 0, 8'h04, 0, 0};
    tbl[11] = '{1, 0, 0, 8'hB1, 1, 8'h04, 0, 0};
    tbl[12] = '{1, 0, 0, 8'hB2, 2, 8'h04, 0, 0};
    tbl[13] = '{1, 1, 0, 8'hA0, 2, 8'hB1, 0, 0};
    tbl[14] = '{1, 1, 0, 8'hA1, 2, 8'hB2, 0, 0};
    tbl[15] = '{1, 1, 0, 8'hA2, 2, 8'hA0, 0, 0};
    tbl[16] = '{1, 1, 0, 8'hA3, 2, 8'hA1, 0, 0};
    tbl[17] = '{1, 1, 0, 8'hA4, 2, 8'hA2, 0, 0};
    tbl[18] = '{1, 1, 0, 8'hA5, 2, 8'hA3, 0, 0};
    tbl[19] = '{1, 0, 0, 8'hC0, 3, 8'hA3, 0, 0};
    tbl[20] = '{1, 0, 0, 8'hC1, 4, 8'hA3, 0, 0};
    tbl[21] = '{1, 1, 0, 8'hC2, 3, 8'hA4, 1, 0};
    tbl[22] = '{0, 1, 0, 8'h00, 2, 8'hA5, 1, 0};
    tbl[23] = '{0, 1, 0, 8'h00, 1, 8'hC0, 1, 0};
    tbl[24] = '{0, 1, 0, 8'h00, 0, 8'hC1, 1, 0};
    tbl[25] = '{1, 1, 0, 8'hD0, 1, 8'hC1, 1, 1};
    tbl[26] = '{0, 0, 1, 8'h00, 1, 8'hC1, 0, 0};
    model_reset();
    #1;
    chk_reset("reset_pre_edge");
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset_held");
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 27; i++) begin
      cyc(tbl[i].w, tbl[i].r, 1'b0, tbl[i].c, tbl[i].d, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.count", i), cnt0, tbl[i].n);
      chk($sformatf("vec%0d.rd_data", i), rd0, tbl[i].r0);
      chk($sformatf("vec%0d.err", i), {ov0, un0}, {tbl[i].o, tbl[i].u});
    end
    cyc(1, 0, 0, 0, 8'hE1, "fill_e1");
    cyc(1, 0, 0, 0, 8'hE2, "fill_e2");
    chk("pre_flush.count", cnt0, 3);
    cyc(1, 0, 1, 0, 8'hE3, "flush");
    chk("flush.count", cnt0, 0);
    chk("flush.empty", emp0, 1);
    chk("flush.rd_data", rd0, 8'h00);
    cyc(1, 0, 0, 0, 8'hF0, "post_flush_wr");
    chk("post_flush.head", rd1, 8'hF0);
    cyc(0, 1, 0, 0, 8'h00, "post_flush_rd");
    chk("post_flush.rd_data", rd0, 8'hF0);
    cyc(1, 0, 0, 0, 8'h31, "burst0");
    cyc(1, 1, 0, 0, 8'h32, "burst1");
    #1;
    reset = 0;
    #1;
    chk_reset("async_reset");
    model_reset();
    wr = 0;
    rd = 0;
    @(posedge clk);
    #1;
    chk_reset("async_reset_held");
    @(negedge clk);
    reset = 1;
    cyc(1, 0, 0, 0, 8'h11, "fwft_w11");
    chk("fwft.first", rd1, 8'h11);
    chk("fwft.not_empty", emp1, 0);
    cyc(1, 0, 0, 0, 8'h22, "fwft_w22");
    chk("fwft.head_held", rd1, 8'h11);
    cyc(0, 1, 0, 0, 8'h00, "fwft_rd1");
    chk("fwft.second", rd1, 8'h22);
    cyc(0, 1, 0, 0, 8'h00, "fwft_rd2");
    chk("fwft.empty", emp1, 1);
    chk("fwft.reg_path", rd0, 8'h22);
    for (int i = 0; i < 800; i++) begin
      int wb = ((i / 64) % 2 == 0) ? 70 : 30;
      cyc($urandom_range(0, 99) < wb, $urandom_range(0, 99) < 100 - wb,
          $urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
          8'($urandom), $sformatf("rnd%0d", i));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
